// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Sequencer for the systolic-array datapath. On an accepted start it loads N
// weight rows, then streams cfg_len input vectors from the unified buffer, and
// then lets the skewed array pipeline drain for LAT = 2N-1 cycles. After that
// it pulses done for one cycle and returns to idle.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   start              command strobe, sampled only in IDLE
//   cfg_len            number of input vectors (0 goes straight to DONE)
//   cfg_w_base         first weight-row address
//   cfg_x_base         first input-vector address
//   stall              buffer not ready; freezes LOAD_W / STREAM progress
//   busy               high in every state except IDLE
//   done               one-cycle pulse in DONE
//   acc_clear          clear the array accumulators (first LOAD_W cycle)
//   w_load/w_row/w_addr   weight-row strobe, row index and read address
//   x_valid/x_addr        input-vector strobe and read address (wraps)
//   y_valid            x_valid delayed by LAT cycles
//   perf_stall_cycles  stalled LOAD_W/STREAM cycle count
//
// Optional build macro SEQ_PERF_CNT_EN: when it is defined, the stall
// performance counter is built. When it is undefined, perf_stall_cycles is 0.
//
// N must be at least 2.
// -----------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int N      = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              acc_clear,
    output logic              w_load,
    output logic [ROW_W-1:0]  w_row,
    output logic [ADDR_W-1:0] w_addr,
    output logic              x_valid,
    output logic [ADDR_W-1:0] x_addr,
    output logic              y_valid,
    output logic [15:0]       perf_stall_cycles
);

    localparam int LAT     = 2 * N - 1;
    localparam int DRAIN_W = $clog2(LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ROW_W-1:0]   row;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len_q;
    logic [ADDR_W-1:0]  w_base_q;
    logic [ADDR_W-1:0]  x_base_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [LAT-1:0]     y_pipe;
    logic               first_load;

    logic start_ok;
    logic start_run;
    logic last_row;
    logic last_vec;
    logic drain_end;

    // Next-state and output decode
    // NOTE: every signal is given a default at the top of the block. If a path
    // did not assign a signal, synthesis would infer a latch for it.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        acc_clear  = 1'b0;
        w_load     = 1'b0;
        w_row      = '0;
        w_addr     = '0;
        x_valid    = 1'b0;
        x_addr     = '0;
        y_valid    = y_pipe[LAT-1];

        start_ok  = (state == S_IDLE) && start;
        start_run = start_ok && (cfg_len != '0);

        unique case (state)
            S_IDLE: begin
                if (start_ok) state_next = start_run ? S_LOAD_W : S_DONE;
            end
            S_LOAD_W: begin
                busy      = 1'b1;
                acc_clear = first_load;
                w_load    = !stall;
                w_row     = row;
                w_addr    = w_base_q + ADDR_W'(row);
                if (w_load && (row == ROW_W'(N - 1))) state_next = S_STREAM;
            end
            S_STREAM: begin
                busy    = 1'b1;
                x_valid = !stall;
                // The address wraps modulo 2^ADDR_W by truncation.
                x_addr  = x_base_q + ADDR_W'(idx);
                if (x_valid && (idx == len_q - LEN_W'(1))) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_W'(LAT - 1)) state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        last_row  = w_load && (row == ROW_W'(N - 1));
        last_vec  = x_valid && (idx == len_q - LEN_W'(1));
        drain_end = (state == S_DRAIN) && (drain_cnt == DRAIN_W'(LAT - 1));
    end

    // State, counters, latched config and the y_valid delay line
    // NOTE: sequential state uses non-blocking assignments only. This way every
    // register samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the config registers and the delay line are reset as well
            // as the FSM. After a reset in the middle of an operation, no old
            // y_valid and no old address can leak into the next command.
            state      <= S_IDLE;
            row        <= '0;
            idx        <= '0;
            len_q      <= '0;
            w_base_q   <= '0;
            x_base_q   <= '0;
            drain_cnt  <= '0;
            y_pipe     <= '0;
            first_load <= 1'b0;
        end else begin
            state      <= state_next;
            first_load <= start_run;

            if (start_run) begin
                len_q    <= cfg_len;
                w_base_q <= cfg_w_base;
                x_base_q <= cfg_x_base;
            end

            if (start_ok)    row <= '0;
            else if (w_load) row <= last_row ? '0 : row + ROW_W'(1);

            if (start_ok)     idx <= '0;
            else if (x_valid) idx <= last_vec ? '0 : idx + LEN_W'(1);

            drain_cnt <= (state == S_DRAIN && !drain_end) ? drain_cnt + DRAIN_W'(1) : '0;

            // The array clocks freely, so the delay line shifts every cycle,
            // stalled or not. Gaps caused by a stall travel through it.
            if (state == S_IDLE) y_pipe <= '0;
            else                 y_pipe <= (y_pipe << 1) | LAT'(x_valid);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (stall && (state == S_LOAD_W || state == S_STREAM)
                     && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//
// Self-checking bench for systolic_seq_ctrl with N=4, ADDR_W=8, LEN_W=8.
// A task turns each scenario into a table of per-cycle records. Each record
// holds the inputs and the expected outputs, taken from the command timeline:
// the load rows, the streamed vectors, LAT drain cycles and done. y_valid is
// x_valid shifted by LAT. The bench applies the records one per cycle. It
// pushes the expected output to a scoreboard when it drives a record and pops
// and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

    localparam int N   = 4;
    localparam int LAT = 2 * N - 1;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       reset;
        logic       start;
        logic       stall;
        logic [7:0] len;
        logic [7:0] wb;
        logic [7:0] xb;
    } in_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        acc_clear;
        logic        w_load;
        logic [1:0]  w_row;
        logic [7:0]  w_addr;
        logic        x_valid;
        logic [7:0]  x_addr;
        logic        y_valid;
        logic [15:0] perf;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
        bit   ls;     // cycle is in LOAD_W or STREAM (counts toward perf)
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic [7:0]  cfg_len, cfg_w_base, cfg_x_base;
    logic        busy, done, acc_clear, w_load, x_valid, y_valid;
    logic [1:0]  w_row;
    logic [7:0]  w_addr, x_addr;
    logic [15:0] perf_stall_cycles;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   perf_hold = 0;
    vec_t vecs[$];
    out_t sb[$];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(N), .ADDR_W(8), .LEN_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .cfg_len           (cfg_len),
        .cfg_w_base        (cfg_w_base),
        .cfg_x_base        (cfg_x_base),
        .stall             (stall),
        .busy              (busy),
        .done              (done),
        .acc_clear         (acc_clear),
        .w_load            (w_load),
        .w_row             (w_row),
        .w_addr            (w_addr),
        .x_valid           (x_valid),
        .x_addr            (x_addr),
        .y_valid           (y_valid),
        .perf_stall_cycles (perf_stall_cycles)
    );

    task automatic check(input string name, input int k, input out_t exp);
        out_t act;
        act = {busy, done, acc_clear, w_load, w_row, w_addr,
               x_valid, x_addr, y_valid, perf_stall_cycles};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got busy=%b done=%b clr=%b wld=%b row=%0d wa=%h xv=%b xa=%h yv=%b perf=%0d ; want busy=%b done=%b clr=%b wld=%b row=%0d wa=%h xv=%b xa=%h yv=%b perf=%0d",
                     name, k, act.busy, act.done, act.acc_clear, act.w_load, act.w_row,
                     act.w_addr, act.x_valid, act.x_addr, act.y_valid, act.perf,
                     exp.busy, exp.done, exp.acc_clear, exp.w_load, exp.w_row,
                     exp.w_addr, exp.x_valid, exp.x_addr, exp.y_valid, exp.perf);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Record for cycle offset c. The cfg inputs carry junk values, so any re-latch shows up.
    function automatic vec_t blank(input int c, input logic [63:0] m);
        vec_t v;
        v.in       = '0;
        v.exp      = '0;
        v.ls       = 1'b0;
        v.in.len   = 8'h09;
        v.in.wb    = 8'hAA;
        v.in.xb    = 8'hBB;
        v.in.stall = (c < 64) ? m[c] : 1'b0;
        return v;
    endfunction

    task automatic build(input int len, input logic [7:0] wb, input logic [7:0] xb,
                         input logic [63:0] stall_m, input int restart_at,
                         input int reset_at);
        vec_t v;
        int   c;
        int   perf;
        bit   issued;
        vecs.delete();
        // Offset 0: the start is driven while the DUT is still idle
        v          = blank(0, stall_m);
        v.in.start = 1'b1;
        v.in.len   = 8'(len);
        v.in.wb    = wb;
        v.in.xb    = xb;
        vecs.push_back(v);
        c = 1;
        if (len == 0) begin
            v = blank(c, stall_m); v.exp.busy = 1'b1; v.exp.done = 1'b1;
            vecs.push_back(v); c++;
        end else begin
            for (int r = 0; r < N; r++) begin
                issued = 1'b0;
                while (!issued) begin
                    v = blank(c, stall_m);
                    v.ls            = 1'b1;
                    v.exp.busy      = 1'b1;
                    v.exp.acc_clear = (c == 1);
                    v.exp.w_load    = !v.in.stall;
                    v.exp.w_row     = 2'(r);
                    v.exp.w_addr    = wb + 8'(r);
                    issued          = !v.in.stall;
                    vecs.push_back(v); c++;
                end
            end
            for (int i = 0; i < len; i++) begin
                issued = 1'b0;
                while (!issued) begin
                    v = blank(c, stall_m);
                    v.ls          = 1'b1;
                    v.exp.busy    = 1'b1;
                    v.exp.x_valid = !v.in.stall;
                    v.exp.x_addr  = xb + 8'(i);
                    issued        = !v.in.stall;
                    vecs.push_back(v); c++;
                end
            end
            for (int d = 0; d < LAT; d++) begin
                v = blank(c, stall_m); v.exp.busy = 1'b1;
                vecs.push_back(v); c++;
            end
            v = blank(c, stall_m); v.exp.busy = 1'b1; v.exp.done = 1'b1;
            vecs.push_back(v); c++;
        end
        v = blank(c, stall_m);
        vecs.push_back(v);

        // y_valid is x_valid shifted by LAT. perf counts earlier stalled load/stream cycles.
        vecs[0].exp.perf = 16'(perf_hold);
        perf = 0;
        for (int k = 1; k < vecs.size(); k++) begin
            if (k >= LAT) vecs[k].exp.y_valid = vecs[k - LAT].exp.x_valid;
            vecs[k].exp.perf = PERF_EN ? 16'(perf) : 16'h0;
            if (vecs[k].ls && vecs[k].in.stall) perf++;
        end
        perf_hold = PERF_EN ? int'(vecs[vecs.size() - 1].exp.perf) : 0;

        if (restart_at > 0) begin
            vecs[restart_at].in.start = 1'b1;
            vecs[restart_at].in.len   = 8'h05;
        end
        if (reset_at > 0) begin
            vecs[reset_at].in.reset = 1'b1;
            while (vecs.size() > reset_at + 2) void'(vecs.pop_back());
            vecs[reset_at + 1]          = blank(64, 64'h0);
            perf_hold                   = 0;
        end
    endtask

    task automatic run_vecs(input string name);
        for (int k = 0; k < vecs.size(); k++) begin
            reset      = vecs[k].in.reset;
            start      = vecs[k].in.start;
            stall      = vecs[k].in.stall;
            cfg_len    = vecs[k].in.len;
            cfg_w_base = vecs[k].in.wb;
            cfg_x_base = vecs[k].in.xb;
            sb.push_back(vecs[k].exp);
            @(negedge clk);
            check(name, k, sb.pop_front());
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;
        int yv;
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        cfg_len = '0; cfg_w_base = '0; cfg_x_base = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", 0, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        build(3, 8'h10, 8'h40, 64'h0, 0, 0);            run_vecs("basic");
        build(3, 8'h10, 8'h40, 64'h44, 0, 0);           run_vecs("stall");
        build(0, 8'h10, 8'h40, 64'h0, 0, 0);            run_vecs("len0");
        build(3, 8'h10, 8'hFE, 64'h400, 0, 0);          run_vecs("xwrap_drainstall");
        build(3, 8'h10, 8'h40, 64'h0, 6, 0);            run_vecs("restart_ignored");
        build(3, 8'h10, 8'h40, 64'h0, 0, 12);           run_vecs("reset_in_drain");
        build(3, 8'h10, 8'h40, 64'h0, 0, 0);            run_vecs("after_reset");

        // Hand sequence: a longer command, with a bounded wait for done
        start = 1'b1; cfg_len = 8'd5; cfg_w_base = 8'h20; cfg_x_base = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        yv = 0;
        while (!done && cycles < 60) begin
            yv += int'(y_valid);
            @(posedge clk); #1;
            cycles++;
        end
        check_int("done_latency_len5", cycles, N + 5 + LAT + 1);
        check_int("y_valid_count_len5", yv, 5);
        @(posedge clk); #1;
        check_int("idle_after_done", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
